// File: rtl/exp_addsub_pipe.sv
// Two-stage exponent add/subtract unit with valid/ready flow control.
// Optional EXP_SPECIAL_EN adds zero/inf operand classes and forces shift_amt to 0 for inf/NaN.
module exp_addsub_pipe #(
   parameter int EXP_W     = 8,
   parameter int BIAS      = 127,
   parameter int MAX_SHIFT = 26,
   parameter int SHIFT_W   = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [EXP_W-1:0]   dataa,
   input  logic [EXP_W-1:0]   datab,
   input  logic               add_sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W-1:0]   result,
   output logic               select,
   output logic [SHIFT_W-1:0] shift_amt,
   output logic               ovf,
   output logic               unf
`ifdef EXP_SPECIAL_EN
   ,
   output logic [1:0]         spec_a,
   output logic [1:0]         spec_b
`endif
);

   localparam int RW = EXP_W + 2;

   logic               r_rdy;
   logic               r_s1_valid;
   logic               r_s1_add;
   logic [RW-1:0]      r_s1_raw;
   logic               r_out_valid;
   logic [EXP_W-1:0]   r_result;
   logic               r_select;
   logic [SHIFT_W-1:0] r_shift;
   logic               r_ovf;
   logic               r_unf;

   logic               w_s2_adv;
   logic               w_s1_adv;
   logic               w_accept;
   logic [RW-1:0]      w_ea;
   logic [RW-1:0]      w_eb;
   logic [RW-1:0]      w_raw_in;
   logic               w_neg;
   logic               w_big;
   logic [EXP_W-1:0]   w_mag;
   logic [SHIFT_W-1:0] w_sat;
   logic               w_force0;

   logic [EXP_W-1:0]   w_n_result;
   logic               w_n_select;
   logic [SHIFT_W-1:0] w_n_shift;
   logic               w_n_ovf;
   logic               w_n_unf;

   assign w_s2_adv = !r_out_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   // r_rdy keeps the input closed for the first cycle after reset release
   assign in_ready = r_rdy && w_s1_adv;
   assign w_accept = in_valid && in_ready;

   assign w_ea     = {2'b00, dataa};
   assign w_eb     = {2'b00, datab};
   assign w_raw_in = add_sub ? (w_ea + w_eb - RW'(BIAS)) : (w_ea - w_eb);

   // raw is two's complement; bit EXP_W set while non-negative means above all-ones
   assign w_neg = r_s1_raw[RW-1];
   assign w_big = !w_neg && r_s1_raw[EXP_W];
   assign w_mag = w_neg ? (EXP_W'(0) - r_s1_raw[EXP_W-1:0]) : r_s1_raw[EXP_W-1:0];
   assign w_sat = (w_mag > EXP_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : w_mag[SHIFT_W-1:0];

`ifdef EXP_SPECIAL_EN
   function automatic logic [1:0] f_cls(input logic [EXP_W-1:0] e);
      if (&e)       return 2'b10;
      else if (~|e) return 2'b01;
      else          return 2'b00;
   endfunction

   logic [1:0] r_s1_spa, r_s1_spb, r_spa, r_spb;

   assign w_force0 = (r_s1_spa == 2'b10) || (r_s1_spb == 2'b10);
   assign spec_a   = r_spa;
   assign spec_b   = r_spb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_spa <= 2'b00;
         r_s1_spb <= 2'b00;
         r_spa    <= 2'b00;
         r_spb    <= 2'b00;
      end else begin
         if (w_accept) begin
            r_s1_spa <= f_cls(dataa);
            r_s1_spb <= f_cls(datab);
         end
         if (w_s2_adv && r_s1_valid) begin
            r_spa <= r_s1_spa;
            r_spb <= r_s1_spb;
         end
      end
   end
`else
   assign w_force0 = 1'b0;
`endif

   always_comb begin
      w_n_result = '0;
      w_n_select = 1'b0;
      w_n_shift  = '0;
      w_n_ovf    = 1'b0;
      w_n_unf    = 1'b0;
      if (r_s1_add) begin
         w_n_ovf = w_big;
         w_n_unf = w_neg;
         if (w_big)       w_n_result = '1;
         else if (!w_neg) w_n_result = r_s1_raw[EXP_W-1:0];
      end else begin
         w_n_select = w_neg;
         w_n_result = w_mag;
         w_n_shift  = w_force0 ? '0 : w_sat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy       <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_add    <= 1'b0;
         r_s1_raw    <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_select    <= 1'b0;
         r_shift     <= '0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (w_s1_adv) r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_add <= add_sub;
            r_s1_raw <= w_raw_in;
         end
         if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_result <= w_n_result;
               r_select <= w_n_select;
               r_shift  <= w_n_shift;
               r_ovf    <= w_n_ovf;
               r_unf    <= w_n_unf;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign select    = r_select;
   assign shift_amt = r_shift;
   assign ovf       = r_ovf;
   assign unf       = r_unf;

endmodule

// File: tb/tb_exp_addsub_pipe.sv
// Scoreboard bench for exp_addsub_pipe: directed plan items, stall, reset flush, random traffic.
module tb_exp_addsub_pipe;

   localparam int EXP_W = 8, BIAS = 127, MAX_SHIFT = 26, SHIFT_W = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b1, add_sub = 1'b0;
   logic in_ready, out_valid, select, ovf, unf;
   logic [EXP_W-1:0] dataa = '0, datab = '0, result;
   logic [SHIFT_W-1:0] shift_amt;
`ifdef EXP_SPECIAL_EN
   logic [1:0] spec_a, spec_b;
`endif

   exp_addsub_pipe #(.EXP_W(EXP_W), .BIAS(BIAS), .MAX_SHIFT(MAX_SHIFT), .SHIFT_W(SHIFT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dataa(dataa), .datab(datab), .add_sub(add_sub), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .select(select), .shift_amt(shift_amt),
      .ovf(ovf), .unf(unf)
`ifdef EXP_SPECIAL_EN
      , .spec_a(spec_a), .spec_b(spec_b)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int res; int sel; int sh; int ov; int un; int sa; int sb;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0, n_err = 0;
   bit rnd_on = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int cls(input int e);
      if (e == 255) return 2;
      if (e == 0)   return 1;
      return 0;
   endfunction

   function automatic exp_t model(input int a, input int b, input bit m);
      exp_t e;
      int s;
      e = '{0, 0, 0, 0, 0, cls(a), cls(b)};
      if (m) begin
         s = a + b - BIAS;
         e.ov = (s > 255) ? 1 : 0;
         e.un = (s < 0) ? 1 : 0;
         e.res = (s > 255) ? 255 : (s < 0) ? 0 : s;
      end else begin
         s = a - b;
         e.sel = (s < 0) ? 1 : 0;
         e.res = (s < 0) ? -s : s;
         e.sh = (e.res > MAX_SHIFT) ? MAX_SHIFT : e.res;
`ifdef EXP_SPECIAL_EN
         if (a == 255 || b == 255) e.sh = 0;
`endif
      end
      return e;
   endfunction

   task automatic send(input int a, input int b, input bit m);
      int w = 0;
      @(posedge clk); #1;
      dataa = a[EXP_W-1:0]; datab = b[EXP_W-1:0]; add_sub = m; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(model(a, b, m));
            break;
         end
         w++;
         if (w > 200) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (q.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk("drain_left", q.size(), 0);
   endtask

   // Monitor: scoreboard pop on transfer, stability check while stalled
   logic hold_v = 1'b0;
   logic [EXP_W-1:0] h_res;
   logic [SHIFT_W-1:0] h_sh;
   logic [2:0] h_flags;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) hold_v = 1'b0;
      else begin
         if (out_valid && !out_ready) begin
            if (hold_v) begin
               chk("hold_result", result, h_res);
               chk("hold_shift", shift_amt, h_sh);
               chk("hold_flags", {select, ovf, unf}, h_flags);
            end
            hold_v = 1'b1; h_res = result; h_sh = shift_amt; h_flags = {select, ovf, unf};
         end else hold_v = 1'b0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               e = q.pop_front();
               chk("result", result, e.res);
               chk("select", select, e.sel);
               chk("shift_amt", shift_amt, e.sh);
               chk("ovf", ovf, e.ov);
               chk("unf", unf, e.un);
`ifdef EXP_SPECIAL_EN
               chk("spec_a", spec_a, e.sa);
               chk("spec_b", spec_b, e.sb);
`endif
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_on) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {select, ovf, unf}, 0);
      chk("rst_shift", shift_amt, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // first beat also checks the 2-cycle latency
      send(130, 127, 1'b0);
      idle();
      @(negedge clk); chk("lat_cycle1", out_valid, 0);
      @(negedge clk); chk("lat_cycle2", out_valid, 1);

      send(100, 140, 1'b0);
      send(200, 200, 1'b1);
      send(50, 50, 1'b1);
      send(130, 128, 1'b1);
      send(77, 77, 1'b0);
      send(0, 255, 1'b0);
      send(255, 0, 1'b1);
`ifdef EXP_SPECIAL_EN
      send(255, 10, 1'b0);
      send(0, 10, 1'b0);
`endif
      idle();
      drain();

      // 4 back-to-back beats with a 3-cycle downstream stall
      fork
         begin
            send(140, 130, 1'b0);
            send(20, 60, 1'b0);
            send(150, 140, 1'b1);
            send(5, 9, 1'b0);
            idle();
         end
         begin
            int w = 0;
            do begin @(negedge clk); w++; end while (!out_valid && w < 50);
            chk("stall_seen_valid", out_valid, 1);
            @(posedge clk); #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready, 0);
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      drain();

      // reset with two beats in flight
      send(90, 30, 1'b0);
      send(60, 61, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1 chk("rst_async_valid", out_valid, 0);
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("post_rst_in_ready", in_ready, 1);
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_no_stale", out_valid, 0);
      end

      // random traffic with random backpressure
      rnd_on = 1'b1;
      for (int i = 0; i < 40; i++)
         send($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      idle();
      rnd_on = 1'b0;
      @(posedge clk); #2 out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
